// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default frame geometry.
// Kept separate so a future uart_tx can reuse the same constants.
package uart_pkg;

  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_DATA_BITS  = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
// The reset value is a parameter so an idle-high serial line synchronizes to 1 from reset.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops give the first stage a full cycle to resolve metastability.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start, DATA_BITS payload bits LSB first, optional odd parity, one stop bit.
// Every bit is sampled at its middle using the OVERSAMPLE x baud tick enable.
// Received bytes are offered through a one-entry valid/ready holding register.
// Build option: define UART_RX_PARITY_EN to add an odd-parity bit and the parity_err port.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic                 CLK100MHZ,
  input  logic                 resetn,
  input  logic                 rx_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] MID_TICK  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

  logic                 rxs;
  rx_state_t            state_q, state_d;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 frame_err_q, frame_err_d;
  logic                 deliver;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 overrun_q;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit_q, par_bit_d;
  logic                 parity_err_q, parity_err_d;
  logic                 parity_ok;

  assign parity_ok = ^{shift_q, par_bit_q};
`endif

  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_rx_sync (
    .clk_i (CLK100MHZ),
    .rst_ni(resetn),
    .d_i   (rx),
    .q_o   (rxs)
  );

  // Frame FSM: counters only move on rx_tick, so a missing tick simply freezes the frame.
  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    deliver     = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_d    = par_bit_q;
    parity_err_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (!rxs) begin
          state_d    = START;
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
        end
      end
      START: begin
        if (rx_tick) begin
          if (tick_cnt_q == MID_TICK) begin
            tick_cnt_d = '0;
            state_d    = rxs ? IDLE : DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (rx_tick) begin
          if (tick_cnt_q == LAST_TICK) begin
            tick_cnt_d = '0;
            shift_d    = {rxs, shift_q[DATA_BITS-1:1]};
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
              state_d   = PARITY;
`else
              state_d   = STOP;
`endif
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (rx_tick) begin
          if (tick_cnt_q == LAST_TICK) begin
            tick_cnt_d = '0;
            par_bit_d  = rxs;
            state_d    = STOP;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (rx_tick) begin
          if (tick_cnt_q == LAST_TICK) begin
            tick_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
            parity_err_d = ~parity_ok;
            deliver      = rxs & parity_ok;
`else
            deliver      = rxs;
`endif
            if (rxs) begin
              state_d = IDLE;
            end else begin
              frame_err_d = 1'b1;
              state_d     = BREAK;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
      BREAK: begin
        if (rxs) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM, counter and shift register state; reset mid-frame drops back to IDLE.
  always_ff @(posedge CLK100MHZ or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      par_bit_q    <= par_bit_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  // Holding register: a consume in the same cycle as a delivery frees the slot without a gap.
  always_ff @(posedge CLK100MHZ or negedge resetn) begin
    if (!resetn) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (deliver) begin
        if (!valid_q || rx_ready) begin
          data_q  <= shift_q;
          valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (valid_q && rx_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at 16x oversampling with a tick every 4 clocks.
// Define UART_RX_PARITY_EN to exercise the odd-parity build as well.
module tb_uart_rx;

  localparam int BIT_CLKS = 64;
`ifdef UART_RX_PARITY_EN
  localparam int TICKS_TO_STOP = 8 + 16 * 8 + 16 + 16;
`else
  localparam int TICKS_TO_STOP = 8 + 16 * 8 + 16;
`endif

  logic       clk;
  logic       resetn;
  logic       rx_tick;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  int checkCount = 0;
  int passCount  = 0;

  int         validCycles    = 0;
  int         hsCount        = 0;
  int         frameErrCycles = 0;
  int         overrunCycles  = 0;
  int         parityErrCycles = 0;
  logic [7:0] lastData       = 8'h00;

  int hs0, vc0, fe0, ov0, pe0;
  logic acceptDone;

  uart_rx dut (
    .CLK100MHZ(clk),
    .resetn   (resetn),
    .rx_tick  (rx_tick),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .busy     (busy)
  );

  // 100 MHz-style free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One-cycle tick every 4 clocks, changed just after the rising edge.
  initial begin
    rx_tick = 1'b0;
    forever begin
      repeat (3) @(posedge clk);
      #2 rx_tick = 1'b1;
      @(posedge clk);
      #2 rx_tick = 1'b0;
    end
  end

  // Event monitor on the falling edge: counts pulses, valid cycles and accepted bytes.
  always @(negedge clk) begin
    if (resetn) begin
      if (rx_valid) validCycles++;
      if (rx_valid && rx_ready) begin
        hsCount++;
        lastData = rx_data;
      end
      if (frame_err) frameErrCycles++;
      if (overrun) overrunCycles++;
`ifdef UART_RX_PARITY_EN
      if (parity_err) parityErrCycles++;
`endif
    end
  end

  // Guard against a hung run.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) begin
      passCount++;
    end else begin
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic holdLine(input logic value, input int clocks);
    #2 rx = value;
    repeat (clocks) @(posedge clk);
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic stopBit,
                               input logic parityFlip);
    @(posedge clk);
    holdLine(1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) holdLine(data[i], BIT_CLKS);
`ifdef UART_RX_PARITY_EN
    holdLine((~^data) ^ parityFlip, BIT_CLKS);
`else
    if (parityFlip) $display("[TB] parity flip ignored in this build");
`endif
    holdLine(stopBit, BIT_CLKS);
  endtask

  task automatic snapshot();
    hs0 = hsCount;
    vc0 = validCycles;
    fe0 = frameErrCycles;
    ov0 = overrunCycles;
    pe0 = parityErrCycles;
  endtask

  // Raises rx_ready only for the cycle whose tick is the stop-bit sample.
  task automatic acceptAtStopSample();
    int ticks = 0;
    acceptDone = 1'b0;
    for (int cyc = 0; cyc < 3000 && !acceptDone; cyc++) begin
      @(posedge clk);
      #3;
      if (busy && rx_tick) begin
        ticks++;
        if (ticks == TICKS_TO_STOP) begin
          rx_ready = 1'b1;
          @(posedge clk);
          #3 rx_ready = 1'b0;
          acceptDone = 1'b1;
        end
      end
    end
  endtask

  initial begin
    resetn   = 1'b0;
    rx       = 1'b1;
    rx_ready = 1'b0;
    acceptDone = 1'b0;

    repeat (3) @(posedge clk);
    #2;
    checkOutput("resetData", 32'(rx_data), 32'h00);
    checkOutput("resetValid", 32'(rx_valid), 32'h0);
    checkOutput("resetFrameErr", 32'(frame_err), 32'h0);
    checkOutput("resetOverrun", 32'(overrun), 32'h0);
    checkOutput("resetBusy", 32'(busy), 32'h0);
    resetn = 1'b1;
    repeat (20) @(posedge clk);

    $display("[TB] basic frame 0xA5");
    #2 rx_ready = 1'b1;
    snapshot();
    applyStimulus(8'hA5, 1'b1, 1'b0);
    repeat (8) @(posedge clk);
    #2;
    checkOutput("a5Accepted", 32'(hsCount - hs0), 32'd1);
    checkOutput("a5Data", 32'(lastData), 32'hA5);
    checkOutput("a5ValidOneClk", 32'(validCycles - vc0), 32'd1);
    checkOutput("a5NoFrameErr", 32'(frameErrCycles - fe0), 32'd0);
    checkOutput("a5Idle", 32'(busy), 32'h0);

    $display("[TB] start-bit glitch");
    snapshot();
    @(posedge clk);
    holdLine(1'b0, 8);
    #1;
    checkOutput("glitchBusy", 32'(busy), 32'h1);
    @(posedge clk);
    holdLine(1'b0, 7);
    holdLine(1'b1, 100);
    #1;
    checkOutput("glitchIdle", 32'(busy), 32'h0);
    checkOutput("glitchNoValid", 32'(validCycles - vc0), 32'd0);
    checkOutput("glitchNoFrameErr", 32'(frameErrCycles - fe0), 32'd0);

    $display("[TB] framing error 0x3C");
    snapshot();
    applyStimulus(8'h3C, 1'b0, 1'b0);
    repeat (300) @(posedge clk);
    #2;
    checkOutput("ferrPulse", 32'(frameErrCycles - fe0), 32'd1);
    checkOutput("ferrNoValid", 32'(validCycles - vc0), 32'd0);
    checkOutput("ferrBreakBusy", 32'(busy), 32'h1);
    rx = 1'b1;
    repeat (10) @(posedge clk);
    #2;
    checkOutput("ferrBreakExit", 32'(busy), 32'h0);
    repeat (50) @(posedge clk);

    $display("[TB] overrun with rx_ready low");
    #2 rx_ready = 1'b0;
    snapshot();
    applyStimulus(8'h11, 1'b1, 1'b0);
    #1;
    checkOutput("ovFirstValid", 32'(rx_valid), 32'h1);
    checkOutput("ovFirstData", 32'(rx_data), 32'h11);
    applyStimulus(8'h22, 1'b1, 1'b0);
    #1;
    checkOutput("ovPulse", 32'(overrunCycles - ov0), 32'd1);
    checkOutput("ovDataHeld", 32'(rx_data), 32'h11);
    checkOutput("ovValidHeld", 32'(rx_valid), 32'h1);
    @(posedge clk);
    #2 rx_ready = 1'b1;
    @(posedge clk);
    #2 rx_ready = 1'b0;
    @(negedge clk);
    checkOutput("ovConsumedData", 32'(lastData), 32'h11);
    checkOutput("ovConsumedValid", 32'(rx_valid), 32'h0);

    $display("[TB] consume on the delivery cycle");
    repeat (20) @(posedge clk);
    applyStimulus(8'h11, 1'b1, 1'b0);
    #1;
    checkOutput("sameCycleFirstData", 32'(rx_data), 32'h11);
    snapshot();
    fork
      applyStimulus(8'h22, 1'b1, 1'b0);
      acceptAtStopSample();
    join
    #1;
    checkOutput("sameCycleWindow", 32'(acceptDone), 32'h1);
    checkOutput("sameCycleConsumed", 32'(lastData), 32'h11);
    checkOutput("sameCycleOneHs", 32'(hsCount - hs0), 32'd1);
    checkOutput("sameCycleNewData", 32'(rx_data), 32'h22);
    checkOutput("sameCycleNewValid", 32'(rx_valid), 32'h1);
    checkOutput("sameCycleNoOverrun", 32'(overrunCycles - ov0), 32'd0);
    @(posedge clk);
    #2 rx_ready = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    checkOutput("sameCycleDrained", 32'(rx_valid), 32'h0);

    $display("[TB] reset in the middle of 0x55");
    snapshot();
    @(posedge clk);
    holdLine(1'b0, BIT_CLKS);
    for (int i = 0; i < 4; i++) holdLine(i[0] ? 1'b0 : 1'b1, BIT_CLKS);
    #2;
    checkOutput("midFrameBusy", 32'(busy), 32'h1);
    rx     = 1'b1;
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("midResetBusy", 32'(busy), 32'h0);
    checkOutput("midResetValid", 32'(rx_valid), 32'h0);
    resetn = 1'b1;
    repeat (100) @(posedge clk);
    applyStimulus(8'h0F, 1'b1, 1'b0);
    repeat (8) @(posedge clk);
    #2;
    checkOutput("afterResetOneByte", 32'(hsCount - hs0), 32'd1);
    checkOutput("afterResetData", 32'(lastData), 32'h0F);

`ifdef UART_RX_PARITY_EN
    $display("[TB] odd parity");
    snapshot();
    applyStimulus(8'h01, 1'b1, 1'b1);
    repeat (8) @(posedge clk);
    #2;
    checkOutput("parBadPulse", 32'(parityErrCycles - pe0), 32'd1);
    checkOutput("parBadDropped", 32'(hsCount - hs0), 32'd0);
    snapshot();
    applyStimulus(8'h01, 1'b1, 1'b0);
    repeat (8) @(posedge clk);
    #2;
    checkOutput("parGoodNoErr", 32'(parityErrCycles - pe0), 32'd0);
    checkOutput("parGoodAccepted", 32'(hsCount - hs0), 32'd1);
    checkOutput("parGoodData", 32'(lastData), 32'h01);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
